fprint_compare_scheduler: RTL



---
 rtl/fprint_sched_pkg.sv | 18 +
 rtl/fprint_rr_arbiter.sv | 34 +++
 rtl/fprint_compare_scheduler.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fprint_sched_pkg.sv
// Shared types and defaults for the fingerprint comparator scheduler.
package fprint_sched_pkg;

  localparam int unsigned KEYS_DEFAULT  = 16;
  localparam int unsigned KEY_W_DEFAULT = 4;
  localparam int unsigned CRC_W_DEFAULT = 32;

  localparam logic [1:0] CORE_NONE = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    COMPARE,
    REPORT,
    ADVANCE
  } sched_state_t;

endpackage

// File: rtl/fprint_rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after last_grant,
// wrapping modulo KEYS.
module fprint_rr_arbiter
  import fprint_sched_pkg::*;
#(
  parameter int unsigned KEYS  = KEYS_DEFAULT,
  parameter int unsigned KEY_W = KEY_W_DEFAULT
) (
  input  logic [KEYS-1:0]  req,
  input  logic [KEY_W-1:0] last_grant,
  output logic [KEY_W-1:0] grant,
  output logic             any
);

  int unsigned      sum;
  logic [KEY_W-1:0] idx;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    sum   = 0;
    idx   = '0;
    // Offset KEYS lands back on last_grant itself, so it has lowest priority.
    for (int unsigned i = 1; i <= KEYS; i++) begin
      sum = 32'(last_grant) + i;
      idx = KEY_W'(sum % KEYS);
      if (!any && req[idx]) begin
        grant = idx;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fprint_compare_scheduler.sv
// Grants one checked-in task at a time, fetches and votes on its fingerprints,
// reports the verdict and advances tail pointers. FPRINT_TMR_VOTE_EN selects TMR vote.
module fprint_compare_scheduler
  import fprint_sched_pkg::*;
#(
  parameter int unsigned KEYS  = KEYS_DEFAULT,
  parameter int unsigned KEY_W = KEY_W_DEFAULT,
  parameter int unsigned CRC_W = CRC_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [KEYS-1:0]  fprint_checkin,
  output logic             fetch_req,
  output logic [KEY_W-1:0] fetch_task,
  input  logic             fetch_valid,
  input  logic [CRC_W-1:0] fprint0,
  input  logic [CRC_W-1:0] fprint1,
  input  logic [CRC_W-1:0] fprint2,
  output logic             comparator_task_verified,
  output logic [KEY_W-1:0] comparator_task,
  output logic             comparator_mismatch,
  output logic [1:0]       comparator_mismatch_core,
  input  logic             fprint_task_verified_ack,
  output logic             comp_inc_tail_pointer,
  output logic [KEY_W-1:0] comp_tail_task,
  output logic             busy
);

  sched_state_t     state, state_next;
  logic [KEY_W-1:0] task_q;
  logic [KEY_W-1:0] last_grant;
  logic [KEY_W-1:0] grant_id;
  logic             grant_any;
  logic [CRC_W-1:0] fp0_q, fp1_q;
  logic             mismatch_q;
  logic [1:0]       core_q;
  logic             vote_mismatch;
  logic [1:0]       vote_core;

  fprint_rr_arbiter #(
    .KEYS  (KEYS),
    .KEY_W (KEY_W)
  ) u_arb (
    .req        (fprint_checkin),
    .last_grant (last_grant),
    .grant      (grant_id),
    .any        (grant_any)
  );

`ifdef FPRINT_TMR_VOTE_EN
  logic [CRC_W-1:0] fp2_q;
  logic             eq01, eq02, eq12;

  assign eq01 = (fp0_q == fp1_q);
  assign eq02 = (fp0_q == fp2_q);
  assign eq12 = (fp1_q == fp2_q);

  always_comb begin
    vote_mismatch = 1'b1;
    vote_core     = CORE_NONE;
    if (eq01 && eq12) begin
      vote_mismatch = 1'b0;
    end else if (eq12) begin
      vote_core = 2'd0;
    end else if (eq02) begin
      vote_core = 2'd1;
    end else if (eq01) begin
      vote_core = 2'd2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fp2_q <= '0;
    end else if (state == FETCH && fetch_valid) begin
      fp2_q <= fprint2;
    end
  end
`else
  logic unused_fprint2;

  assign unused_fprint2 = ^fprint2;
  assign vote_mismatch  = (fp0_q != fp1_q);
  assign vote_core      = CORE_NONE;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_any) state_next = FETCH;
      FETCH:   if (fetch_valid) state_next = COMPARE;
      COMPARE: state_next = REPORT;
      REPORT:  if (fprint_task_verified_ack) state_next = ADVANCE;
      ADVANCE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      task_q     <= '0;
      last_grant <= KEY_W'(KEYS - 1);
      fp0_q      <= '0;
      fp1_q      <= '0;
      mismatch_q <= 1'b0;
      core_q     <= CORE_NONE;
    end else begin
      state <= state_next;
      if (state == IDLE && grant_any) begin
        task_q     <= grant_id;
        last_grant <= grant_id;
      end
      if (state == FETCH && fetch_valid) begin
        fp0_q <= fprint0;
        fp1_q <= fprint1;
      end
      if (state == COMPARE) begin
        mismatch_q <= vote_mismatch;
        core_q     <= vote_core;
      end
    end
  end

  assign fetch_req                = (state == FETCH);
  assign fetch_task               = task_q;
  assign comparator_task_verified = (state == REPORT);
  assign comparator_task          = task_q;
  assign comparator_mismatch      = mismatch_q;
  assign comparator_mismatch_core = core_q;
  assign comp_inc_tail_pointer    = (state == ADVANCE);
  assign comp_tail_task           = task_q;
  assign busy                     = (state != IDLE);

endmodule
